// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, opcode constants and queue entry payload for the instruction fetch queue.
// IFQ_PREDECODE_EN adds a per-entry control-flow flag to the payload.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package inst_fetch_queue_pkg;

    localparam int unsigned PC_WIDTH   = `PC_WIDTH;
    localparam int unsigned INST_WIDTH = `INST_WIDTH;

`ifdef IFQ_PREDECODE_EN
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
        logic                  is_ctrl;
    } ifq_entry_t;

    // Branch, jal and jalr all redirect the front end.
    function automatic logic is_ctrl_op(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction
`else
    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } ifq_entry_t;
`endif

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: PC register handshake, instruction memory port and decode valid/ready.
// master is the fetch queue, slave is the surrounding core and memory.
interface inst_fetch_queue_if;
    import inst_fetch_queue_pkg::*;

    logic                  cpu_en;
    logic [PC_WIDTH-1:0]   pc;
    logic                  flush;
    logic                  pc_stall;
    logic                  imem_rd_en;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  ifq_valid;
    logic                  ifq_ready;
    logic [PC_WIDTH-1:0]   ifq_pc;
    logic [INST_WIDTH-1:0] ifq_inst;
    logic                  ifq_is_ctrl;

    modport master (
        input  cpu_en, pc, flush, imem_rdata, ifq_ready,
        output pc_stall, imem_rd_en, imem_addr, ifq_valid, ifq_pc, ifq_inst, ifq_is_ctrl
    );

    modport slave (
        output cpu_en, pc, flush, imem_rdata, ifq_ready,
        input  pc_stall, imem_rd_en, imem_addr, ifq_valid, ifq_pc, ifq_inst, ifq_is_ctrl
    );

endinterface

// File: rtl/ifq_fifo.sv
// Circular-buffer storage for fetched entries: wrapping pointers, occupancy count,
// push/pop with a clear that dominates both.
module ifq_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           push,
    input  ifq_entry_t                     push_data,
    input  logic                           pop,
    output ifq_entry_t                     head,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues pc to a 1-cycle synchronous imem, queues {pc, word} and drains to decode.
// Optional IFQ_PREDECODE_EN macro stores a branch/jal/jalr flag per entry on ifq_is_ctrl.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned IFQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_fetch_queue_if.master  ifc
);

    localparam int unsigned CNT_W = $clog2(IFQ_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic                issue;
    logic                push;
    logic                pop;
    logic                valid;
    logic                stall;
    logic                pending_vld;
    logic [PC_WIDTH-1:0] pending_pc;
    logic [CNT_W-1:0]    count;
    logic [SUM_W-1:0]    occupancy;
    ifq_entry_t          push_data;
    ifq_entry_t          head;

    // Reserve a slot for the in-flight response; a same-cycle pop earns no credit.
    assign occupancy = SUM_W'(count) + SUM_W'(pending_vld);
    assign stall     = (occupancy >= SUM_W'(IFQ_DEPTH));
    assign valid     = (count != '0);

    assign issue = ifc.cpu_en & ~stall & ~ifc.flush;
    assign push  = pending_vld & ~ifc.flush;
    assign pop   = valid & ifc.ifq_ready & ifc.cpu_en;

    // Track the one outstanding memory read; a flush orphans it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_vld <= 1'b0;
            pending_pc  <= '0;
        end else if (ifc.flush) begin
            pending_vld <= 1'b0;
        end else begin
            pending_vld <= issue;
            if (issue) begin
                pending_pc <= ifc.pc;
            end
        end
    end

    always_comb begin
        push_data      = '0;
        push_data.pc   = pending_pc;
        push_data.inst = ifc.imem_rdata;
`ifdef IFQ_PREDECODE_EN
        push_data.is_ctrl = is_ctrl_op(ifc.imem_rdata[6:0]);
`endif
    end

    ifq_fifo #(
        .DEPTH (IFQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ifc.flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign ifc.pc_stall   = stall;
    assign ifc.imem_rd_en = issue;
    assign ifc.imem_addr  = ifc.pc;
    assign ifc.ifq_valid  = valid;
    assign ifc.ifq_pc     = head.pc;
    assign ifc.ifq_inst   = head.inst;
`ifdef IFQ_PREDECODE_EN
    assign ifc.ifq_is_ctrl = head.is_ctrl;
`else
    assign ifc.ifq_is_ctrl = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model plus directed and random scenarios.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_fetch_queue_if ifc();

    inst_fetch_queue #(.IFQ_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    typedef struct {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } ent_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ent_t                mq[$];
    bit                  m_pend;
    logic [PC_WIDTH-1:0] m_pend_pc;
    logic [PC_WIDTH-1:0] redirect_pc;
    bit                  m_stall, m_rd_en, m_valid;
    ent_t                m_head;

`ifdef IFQ_PREDECODE_EN
    localparam bit JAL_CTRL = 1'b1;
`else
    localparam bit JAL_CTRL = 1'b0;
`endif

    // Memory image: two fixed words for predecode, a hash of the address elsewhere.
    function automatic logic [INST_WIDTH-1:0] word_of(input logic [PC_WIDTH-1:0] a);
        logic [31:0] h;
        if (a == PC_WIDTH'(32'h200)) return INST_WIDTH'(32'h0000006F);
        if (a == PC_WIDTH'(32'h204)) return INST_WIDTH'(32'h00000013);
        h = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
        return INST_WIDTH'(h);
    endfunction

    function automatic bit ctrl_of(input logic [INST_WIDTH-1:0] w);
`ifdef IFQ_PREDECODE_EN
        return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
`else
        return (w[0] & 1'b0);
`endif
    endfunction

    // Expected combinational view for the current cycle.
    task automatic settle();
        @(negedge clk);
        cyc++;
        m_valid = (mq.size() != 0);
        m_stall = (mq.size() + int'(m_pend)) >= int'(DEPTH);
        m_rd_en = ifc.cpu_en && !m_stall && !ifc.flush;
        if (m_valid) m_head = mq[0];
    endtask

    // Clock edge: memory, PC register and reference queue all step.
    task automatic advance();
        bit                  pop, push, fl, rd, iss;
        logic [PC_WIDTH-1:0] addr, cur_pc;
        pop    = m_valid && (ifc.ifq_ready === 1'b1) && ifc.cpu_en;
        push   = m_pend && !ifc.flush;
        fl     = ifc.flush;
        rd     = (ifc.imem_rd_en === 1'b1);
        addr   = ifc.imem_addr;
        iss    = m_rd_en;
        cur_pc = ifc.pc;
        @(posedge clk);
        #1;
        ifc.imem_rdata = rd ? word_of(addr) : INST_WIDTH'($urandom);
        if (fl)      ifc.pc = redirect_pc;
        else if (rd) ifc.pc = ifc.pc + PC_WIDTH'(4);
        if (fl) begin
            mq.delete();
            m_pend = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{m_pend_pc, word_of(m_pend_pc)});
            m_pend = iss;
            if (iss) m_pend_pc = cur_pc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.cpu_en = 1'b0; ifc.flush = 1'b0; ifc.ifq_ready = 1'b0;
        ifc.pc = '0; ifc.imem_rdata = '0;
        mq.delete(); m_pend = 1'b0; m_pend_pc = '0; redirect_pc = '0;
        @(negedge clk);
        total++;
        if ({ifc.ifq_valid, ifc.pc_stall, ifc.imem_rd_en} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl got valid/stall/rd=%b%b%b want=000", ifc.ifq_valid, ifc.pc_stall, ifc.imem_rd_en);
        end
        total++;
        if ({ifc.ifq_pc, ifc.ifq_inst, ifc.ifq_is_ctrl} !== '0) begin
            bad++; $display("FAIL reset_head got pc=%h inst=%h ctrl=%b want zeros", ifc.ifq_pc, ifc.ifq_inst, ifc.ifq_is_ctrl);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int first_issue = -1, first_valid = -1;
        logic [PC_WIDTH-1:0] seen[$];
        ifc.cpu_en = 1'b1; ifc.ifq_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            settle();
            total++;
            if ({ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid} !== {m_stall, m_rd_en, m_valid}) begin
                bad++; $display("FAIL stream_ctl cyc=%0d got=%b%b%b want=%b%b%b", cyc, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid, m_stall, m_rd_en, m_valid);
            end
            if (m_valid) begin
                total++;
                if ({ifc.ifq_pc, ifc.ifq_inst} !== {m_head.pc, m_head.inst}) begin
                    bad++; $display("FAIL stream_head cyc=%0d got=%h/%h want=%h/%h", cyc, ifc.ifq_pc, ifc.ifq_inst, m_head.pc, m_head.inst);
                end
            end
            if (ifc.imem_rd_en === 1'b1 && first_issue < 0) first_issue = k;
            if (ifc.ifq_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (ifc.ifq_valid === 1'b1) seen.push_back(ifc.ifq_pc);
            advance();
        end
        total++;
        if (first_issue != 0 || first_valid - first_issue != 2) begin
            bad++; $display("FAIL stream_latency got issue=%0d valid=%0d want issue=0 valid=2", first_issue, first_valid);
        end
        total++;
        if (seen.size() < 3 || seen[0] !== PC_WIDTH'(0) || seen[1] !== PC_WIDTH'(4) || seen[2] !== PC_WIDTH'(8)) begin
            bad++; $display("FAIL stream_order got %0d entries first=%h want 0,4,8", seen.size(), (seen.size() > 0) ? seen[0] : '0);
        end
    endtask

    task automatic test_stall();
        bit st_tab[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        bit rd_tab[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
        ifc.flush = 1'b1; redirect_pc = PC_WIDTH'(32'h100); ifc.ifq_ready = 1'b0;
        settle();
        total++;
        if (ifc.imem_rd_en !== 1'b0) begin
            bad++; $display("FAIL stall_flush_rd got=%b want=0", ifc.imem_rd_en);
        end
        advance();
        ifc.flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ifc.ifq_ready = (k >= 6);
            settle();
            total++;
            if ({ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid} !== {m_stall, m_rd_en, m_valid}) begin
                bad++; $display("FAIL stall_ctl cyc=%0d got=%b%b%b want=%b%b%b", cyc, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid, m_stall, m_rd_en, m_valid);
            end
            total++;
            if ({ifc.pc_stall, ifc.imem_rd_en} !== {st_tab[k], rd_tab[k]}) begin
                bad++; $display("FAIL stall_table k=%0d got stall/rd=%b%b want=%b%b", k, ifc.pc_stall, ifc.imem_rd_en, st_tab[k], rd_tab[k]);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        logic [PC_WIDTH-1:0] popped[$];
        ifc.flush = 1'b1; redirect_pc = PC_WIDTH'(32'h08); ifc.ifq_ready = 1'b0;
        settle(); advance();
        ifc.flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.flush = (k == 3);
            if (k == 3) redirect_pc = PC_WIDTH'(32'h80);
            settle();
            total++;
            if ({ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid} !== {m_stall, m_rd_en, m_valid}) begin
                bad++; $display("FAIL flush_ctl cyc=%0d got=%b%b%b want=%b%b%b", cyc, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid, m_stall, m_rd_en, m_valid);
            end
            advance();
        end
        ifc.flush = 1'b0; ifc.ifq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k == 0) begin
                total++;
                if (ifc.ifq_valid !== 1'b0) begin
                    bad++; $display("FAIL flush_valid got=%b want=0", ifc.ifq_valid);
                end
            end
            if (m_valid) begin
                total++;
                if ({ifc.ifq_pc, ifc.ifq_inst} !== {m_head.pc, m_head.inst}) begin
                    bad++; $display("FAIL flush_head cyc=%0d got=%h/%h want=%h/%h", cyc, ifc.ifq_pc, ifc.ifq_inst, m_head.pc, m_head.inst);
                end
            end
            if (ifc.ifq_valid === 1'b1) popped.push_back(ifc.ifq_pc);
            advance();
        end
        total++;
        if (popped.size() == 0 || popped[0] !== PC_WIDTH'(32'h80) || (PC_WIDTH'(32'h10) inside {popped})) begin
            bad++; $display("FAIL flush_target got first=%h count=%0d want first=80 and no 10", (popped.size() > 0) ? popped[0] : '0, popped.size());
        end
    endtask

    task automatic test_cpu_en();
        ifc.cpu_en = 1'b1; ifc.ifq_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            ifc.cpu_en = !(k >= 2 && k < 5);
            settle();
            total++;
            if ({ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid} !== {m_stall, m_rd_en, m_valid}) begin
                bad++; $display("FAIL cpuen_ctl cyc=%0d got=%b%b%b want=%b%b%b", cyc, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid, m_stall, m_rd_en, m_valid);
            end
            if (m_valid) begin
                total++;
                if ({ifc.ifq_pc, ifc.ifq_inst} !== {m_head.pc, m_head.inst}) begin
                    bad++; $display("FAIL cpuen_head cyc=%0d got=%h/%h want=%h/%h", cyc, ifc.ifq_pc, ifc.ifq_inst, m_head.pc, m_head.inst);
                end
            end
            if (!ifc.cpu_en) begin
                total++;
                if (ifc.imem_rd_en !== 1'b0) begin
                    bad++; $display("FAIL cpuen_noissue cyc=%0d got=%b want=0", cyc, ifc.imem_rd_en);
                end
            end
            advance();
        end
    endtask

    task automatic test_predecode();
        logic [PC_WIDTH-1:0] pcs[$];
        bit                  ctl[$];
        ifc.cpu_en = 1'b1; ifc.ifq_ready = 1'b1;
        ifc.flush = 1'b1; redirect_pc = PC_WIDTH'(32'h200);
        settle(); advance();
        ifc.flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (m_valid) begin
                total++;
                if (ifc.ifq_is_ctrl !== ctrl_of(m_head.inst)) begin
                    bad++; $display("FAIL predecode_flag cyc=%0d got=%b want=%b", cyc, ifc.ifq_is_ctrl, ctrl_of(m_head.inst));
                end
            end
            if (ifc.ifq_valid === 1'b1) begin
                pcs.push_back(ifc.ifq_pc);
                ctl.push_back(ifc.ifq_is_ctrl);
            end
            advance();
        end
        total++;
        if (pcs.size() < 2 || pcs[0] !== PC_WIDTH'(32'h200) || pcs[1] !== PC_WIDTH'(32'h204) || ctl[0] !== JAL_CTRL || ctl[1] !== 1'b0) begin
            bad++; $display("FAIL predecode_pair got n=%0d ctrl=%b,%b want pcs 200,204 ctrl=%b,0", pcs.size(), (ctl.size() > 0) ? ctl[0] : 1'b0, (ctl.size() > 1) ? ctl[1] : 1'b0, JAL_CTRL);
        end
    endtask

    task automatic test_reset_mid();
        ifc.cpu_en = 1'b1; ifc.ifq_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle(); advance();
        end
        #2;
        ifc.cpu_en = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ifc.ifq_valid, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_pc, ifc.ifq_inst} !== '0) begin
            bad++; $display("FAIL reset_mid got valid=%b stall=%b rd=%b pc=%h inst=%h want zeros", ifc.ifq_valid, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_pc, ifc.ifq_inst);
        end
        mq.delete(); m_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ifc.cpu_en    = ($urandom_range(0, 7) != 0);
            ifc.ifq_ready = $urandom_range(0, 1);
            ifc.flush     = ($urandom_range(0, 19) == 0);
            redirect_pc   = PC_WIDTH'({$urandom_range(0, 1023), 2'b00});
            settle();
            total++;
            if ({ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid} !== {m_stall, m_rd_en, m_valid}) begin
                bad++; $display("FAIL random_ctl cyc=%0d got=%b%b%b want=%b%b%b", cyc, ifc.pc_stall, ifc.imem_rd_en, ifc.ifq_valid, m_stall, m_rd_en, m_valid);
            end
            if (m_rd_en) begin
                total++;
                if (ifc.imem_addr !== ifc.pc) begin
                    bad++; $display("FAIL random_addr cyc=%0d got=%h want=%h", cyc, ifc.imem_addr, ifc.pc);
                end
            end
            if (m_valid) begin
                total++;
                if ({ifc.ifq_pc, ifc.ifq_inst, ifc.ifq_is_ctrl} !== {m_head.pc, m_head.inst, ctrl_of(m_head.inst)}) begin
                    bad++; $display("FAIL random_head cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc, ifc.ifq_pc, ifc.ifq_inst, ifc.ifq_is_ctrl, m_head.pc, m_head.inst, ctrl_of(m_head.inst));
                end
            end
            advance();
        end
        ifc.flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_cpu_en();
        test_predecode();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
